t07_timer_countdown_ctrl: RTL and testbench

//   Countdown-timer core feeding t07_timer_ssdec_spi_master. Holds an M:SS preset that the user edits,

---
 rtl/t07_timer_countdown_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_t07_timer_countdown_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t07_timer_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// t07_timer_countdown_ctrl
//
// Countdown-timer core. Holds an M:SS preset that the user edits with the
// increment buttons, counts it down once per second while running, and
// drives the BCD digits plus the display-enable level consumed by the SPI
// display stage (t07_timer_ssdec_spi_master). Inputs come from the
// debounced button / edge-detect stage as single-cycle pulses.
//
// Configuration macro:
//   T07_TIMER_ALARM_EN  - when defined, adds the alarm output generator and
//                         the ALARM_SECS parameter. When undefined, alarm is
//                         tied low and everything else behaves identically.
//
// Parameters:
//   TICK_DIV        clk cycles per 1 s tick (>= 2, even)
//   STARTUP_CYCLES  cycles after rst release before disp_enable asserts
//   DEFAULT_MIN     preset minutes after rst (0..7)
//   DEFAULT_SEC     preset seconds after rst (0..59)
//   ALARM_SECS      alarm duration in seconds (alarm build only)
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   start_stop   in   pulse: start / pause / resume / acknowledge
//   reset_time   in   pulse: abandon run, reload preset, return to SET
//   inc_min      in   pulse: preset minutes +1 (SET only)
//   inc_sec      in   pulse: preset seconds +1 (SET only)
//   cnt_min      out  displayed minutes, 0..7
//   cnt_sec_ten  out  displayed tens of seconds, 0..5
//   cnt_sec_one  out  displayed units of seconds, 0..9
//   disp_enable  out  display stage enable level
//   running      out  high while counting down
//   done         out  high once the count has reached 0:00
//   alarm        out  alarm drive (tied 0 without T07_TIMER_ALARM_EN)
// ---------------------------------------------------------------------------
module t07_timer_countdown_ctrl #(
  parameter int TICK_DIV       = 10_000_000,
  parameter int STARTUP_CYCLES = 1_000_000,
  parameter int DEFAULT_MIN    = 1,
  parameter int DEFAULT_SEC    = 0
`ifdef T07_TIMER_ALARM_EN
  ,
  parameter int ALARM_SECS     = 5
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       reset_time,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [2:0] cnt_min,
  output logic [2:0] cnt_sec_ten,
  output logic [3:0] cnt_sec_one,
  output logic       disp_enable,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  // Counter widths, guarded so degenerate parameter values still give 1 bit.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  localparam logic [PW-1:0] TICK_LAST    = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STARTUP_LAST = SW'(STARTUP_CYCLES - 1);

  localparam logic [2:0] RST_MIN = 3'(DEFAULT_MIN);
  localparam logic [2:0] RST_TEN = 3'(DEFAULT_SEC / 10);
  localparam logic [3:0] RST_ONE = 4'(DEFAULT_SEC % 10);

  typedef enum logic [1:0] {
    S_SET,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    preset_min;
  logic [2:0]    preset_ten;
  logic [3:0]    preset_one;
  logic [PW-1:0] prescaler;
  logic [SW-1:0] startup_cnt;

  logic [2:0]    set_min;
  logic [2:0]    set_ten;
  logic [3:0]    set_one;
  logic [2:0]    dec_min;
  logic [2:0]    dec_ten;
  logic [3:0]    dec_one;
  logic          preset_zero;
  logic          dec_zero;
  logic          tick;

  // Next preset value for the increment buttons. Both buttons may apply in
  // the same cycle; seconds wrap 59 -> 00 without carrying into minutes,
  // and minutes wrap 7 -> 0 through the natural 3-bit overflow.
  always_comb begin
    set_min = preset_min;
    set_ten = preset_ten;
    set_one = preset_one;
    if (inc_min) begin
      set_min = preset_min + 3'd1;
    end
    if (inc_sec) begin
      if (preset_one == 4'd9) begin
        set_one = 4'd0;
        set_ten = (preset_ten == 3'd5) ? 3'd0 : preset_ten + 3'd1;
      end else begin
        set_one = preset_one + 4'd1;
      end
    end
  end

  // One-second decrement of the displayed count with BCD borrow.
  always_comb begin
    dec_min = cnt_min;
    dec_ten = cnt_sec_ten;
    dec_one = cnt_sec_one;
    if (cnt_sec_one != 4'd0) begin
      dec_one = cnt_sec_one - 4'd1;
    end else begin
      dec_one = 4'd9;
      if (cnt_sec_ten != 3'd0) begin
        dec_ten = cnt_sec_ten - 3'd1;
      end else begin
        dec_ten = 3'd5;
        dec_min = cnt_min - 3'd1;
      end
    end
  end

  assign preset_zero = (preset_min == 3'd0) && (preset_ten == 3'd0) && (preset_one == 4'd0);
  assign dec_zero    = (dec_min == 3'd0) && (dec_ten == 3'd0) && (dec_one == 4'd0);
  assign tick        = (prescaler == TICK_LAST);

  // Main control FSM. Per-cycle priority is reset_time, then start_stop,
  // then the increment buttons. In SET the displayed count tracks the
  // preset in the same cycle the preset changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SET;
      preset_min  <= RST_MIN;
      preset_ten  <= RST_TEN;
      preset_one  <= RST_ONE;
      cnt_min     <= RST_MIN;
      cnt_sec_ten <= RST_TEN;
      cnt_sec_one <= RST_ONE;
      prescaler   <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_SET: begin
          if (reset_time) begin
            cnt_min     <= preset_min;
            cnt_sec_ten <= preset_ten;
            cnt_sec_one <= preset_one;
          end else if (start_stop) begin
            // A 0:00 preset has nothing to count, so the start is ignored.
            if (!preset_zero) begin
              state     <= S_RUN;
              prescaler <= '0;
              running   <= 1'b1;
            end
          end else begin
            preset_min  <= set_min;
            preset_ten  <= set_ten;
            preset_one  <= set_one;
            cnt_min     <= set_min;
            cnt_sec_ten <= set_ten;
            cnt_sec_one <= set_one;
          end
        end

        S_RUN: begin
          if (reset_time) begin
            state       <= S_SET;
            running     <= 1'b0;
            cnt_min     <= preset_min;
            cnt_sec_ten <= preset_ten;
            cnt_sec_one <= preset_one;
          end else if (start_stop) begin
            // Prescaler is frozen here. If this was the tick cycle the
            // decrement is skipped and the prescaler stays at its last
            // value, so the first RUN cycle after resuming ticks.
            state   <= S_PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            prescaler   <= '0;
            cnt_min     <= dec_min;
            cnt_sec_ten <= dec_ten;
            cnt_sec_one <= dec_one;
            if (dec_zero) begin
              state   <= S_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end

        S_PAUSE: begin
          if (reset_time) begin
            state       <= S_SET;
            cnt_min     <= preset_min;
            cnt_sec_ten <= preset_ten;
            cnt_sec_one <= preset_one;
          end else if (start_stop) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_DONE: begin
          if (reset_time || start_stop) begin
            state       <= S_SET;
            done        <= 1'b0;
            cnt_min     <= preset_min;
            cnt_sec_ten <= preset_ten;
            cnt_sec_one <= preset_one;
          end
        end

        default: begin
          state   <= S_SET;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // Display boot delay: once the counter has reached its last value the
  // enable is set and the counter stops, so the level holds until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      startup_cnt <= '0;
      disp_enable <= 1'b0;
    end else if (!disp_enable) begin
      if (startup_cnt == STARTUP_LAST) begin
        disp_enable <= 1'b1;
      end else begin
        startup_cnt <= startup_cnt + 1'b1;
      end
    end
  end

`ifdef T07_TIMER_ALARM_EN
  localparam int ALARM_LEN = ALARM_SECS * TICK_DIV;
  localparam int AW        = (ALARM_LEN > 1) ? $clog2(ALARM_LEN) : 1;
  localparam int HALF      = TICK_DIV / 2;
  localparam int HW        = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_LEN - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);

  logic          enter_done;
  logic          leave_done;
  logic          alarm_active;
  logic [AW-1:0] alarm_cnt;
  logic [HW-1:0] half_cnt;

  // Mirrors the FSM conditions for the edge that enters / leaves DONE.
  assign enter_done = (state == S_RUN) && !reset_time && !start_stop && tick && dec_zero;
  assign leave_done = (state == S_DONE) && (reset_time || start_stop);

  // Alarm waveform: high on the edge that enters DONE, toggling every half
  // second, then silenced for good once ALARM_SECS have elapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm        <= 1'b0;
      alarm_active <= 1'b0;
      alarm_cnt    <= '0;
      half_cnt     <= '0;
    end else if (enter_done) begin
      alarm        <= 1'b1;
      alarm_active <= 1'b1;
      alarm_cnt    <= '0;
      half_cnt     <= '0;
    end else if ((state != S_DONE) || leave_done) begin
      alarm        <= 1'b0;
      alarm_active <= 1'b0;
    end else if (alarm_active) begin
      if (alarm_cnt == ALARM_LAST) begin
        alarm        <= 1'b0;
        alarm_active <= 1'b0;
      end else begin
        alarm_cnt <= alarm_cnt + 1'b1;
        if (half_cnt == HALF_LAST) begin
          half_cnt <= '0;
          alarm    <= ~alarm;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_t07_timer_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// tb_t07_timer_countdown_ctrl
//
// Scoreboard bench for the countdown-timer core with TICK_DIV=4 and
// STARTUP_CYCLES=8. Each stimulus cycle pushes the hand-computed expected
// outputs for the following clock edge into a queue, tagged with the cycle
// number it applies to; an independent monitor pops and compares on the
// falling edge. disp_enable and alarm expectations come from small models
// of the startup delay and the alarm waveform.
// ---------------------------------------------------------------------------
module tb_t07_timer_countdown_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int STARTUP   = 8;
  localparam int ALARM_LEN = 5 * TICK_DIV;
  localparam int HALF      = TICK_DIV / 2;
`ifdef T07_TIMER_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_stop;
  logic       reset_time;
  logic       inc_min;
  logic       inc_sec;
  logic [2:0] cnt_min;
  logic [2:0] cnt_sec_ten;
  logic [3:0] cnt_sec_one;
  logic       disp_enable;
  logic       running;
  logic       done;
  logic       alarm;

  typedef struct {
    int         cyc;
    string      tag;
    logic [2:0] m;
    logic [2:0] t;
    logic [3:0] o;
    logic       de;
    logic       run;
    logic       dn;
    logic       al;
  } exp_t;

  exp_t expQueue[$];
  exp_t monItem;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int edgesSinceRst = 0;
  int doneK = -1;
  logic prevExpDone = 1'b0;

  t07_timer_countdown_ctrl #(
    .TICK_DIV(TICK_DIV),
    .STARTUP_CYCLES(STARTUP),
    .DEFAULT_MIN(1),
    .DEFAULT_SEC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .reset_time(reset_time),
    .inc_min(inc_min),
    .inc_sec(inc_sec),
    .cnt_min(cnt_min),
    .cnt_sec_ten(cnt_sec_ten),
    .cnt_sec_one(cnt_sec_one),
    .disp_enable(disp_enable),
    .running(running),
    .done(done),
    .alarm(alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e);
    total++;
    if (cnt_min !== e.m || cnt_sec_ten !== e.t || cnt_sec_one !== e.o ||
        disp_enable !== e.de || running !== e.run || done !== e.dn || alarm !== e.al) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got %0d:%0d%0d de=%b run=%b done=%b al=%b required %0d:%0d%0d de=%b run=%b done=%b al=%b",
               e.tag, e.cyc, cnt_min, cnt_sec_ten, cnt_sec_one, disp_enable, running, done, alarm,
               e.m, e.t, e.o, e.de, e.run, e.dn, e.al);
    end
  endtask

  // Monitor: compare every queued expectation that targets this cycle.
  always @(negedge clk) begin
    while (expQueue.size() > 0 && expQueue[0].cyc == cyc) begin
      monItem = expQueue.pop_front();
      checkOutput(monItem);
    end
  end

  task automatic pushExpect(input string tag, input int em, input int et, input int eo,
                            input logic ede, input logic er, input logic ed, input logic ea);
    exp_t e;
    e.cyc = cyc + 1;
    e.tag = tag;
    e.m   = 3'(em);
    e.t   = 3'(et);
    e.o   = 4'(eo);
    e.de  = ede;
    e.run = er;
    e.dn  = ed;
    e.al  = ea;
    expQueue.push_back(e);
  endtask

  // One clock of stimulus with the expected outputs after that edge.
  task automatic applyStimulus(input string tag, input logic ss, input logic rt,
                               input logic im, input logic isec,
                               input int em, input int et, input int eo,
                               input logic er, input logic ed);
    logic ea;
    start_stop = ss;
    reset_time = rt;
    inc_min    = im;
    inc_sec    = isec;
    edgesSinceRst++;
    if (ed) doneK = prevExpDone ? doneK + 1 : 0;
    else    doneK = -1;
    prevExpDone = ed;
    ea = ALARM_ON && (doneK >= 0) && (doneK < ALARM_LEN) && (((doneK / HALF) % 2) == 0);
    pushExpect(tag, em, et, eo, (edgesSinceRst >= STARTUP), er, ed, ea);
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    reset_time = 1'b0;
    inc_min    = 1'b0;
    inc_sec    = 1'b0;
  endtask

  task automatic holdCycles(input string tag, input int n, input int em, input int et,
                            input int eo, input logic er, input logic ed);
    for (int i = 0; i < n; i++) begin
      applyStimulus($sformatf("%s_%0d", tag, i), 1'b0, 1'b0, 1'b0, 1'b0, em, et, eo, er, ed);
    end
  endtask

  task automatic doReset();
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      pushExpect($sformatf("reset_%0d", i), 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    edgesSinceRst = 0;
    doneK = -1;
    prevExpDone = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b0;
    start_stop = 1'b0;
    reset_time = 1'b0;
    inc_min = 1'b0;
    inc_sec = 1'b0;

    doReset();
    holdCycles("startup", 10, 1, 0, 0, 1'b0, 1'b0);

    // Seconds wrap 59 -> 00 with minutes untouched.
    for (int i = 1; i <= 60; i++) begin
      s = i % 60;
      applyStimulus($sformatf("inc_sec_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1, s / 10, s % 10, 1'b0, 1'b0);
    end
    // Minutes 1 -> 7 -> 0.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus($sformatf("inc_min_%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, (1 + i) % 8, 0, 0, 1'b0, 1'b0);
    end
    applyStimulus("start_at_zero", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);

    // Preset 0:03 and count down to DONE.
    applyStimulus("pre03_a", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 1'b0, 1'b0);
    applyStimulus("pre03_b", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 2, 1'b0, 1'b0);
    applyStimulus("pre03_c", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 3, 1'b0, 1'b0);
    applyStimulus("start_beats_inc", 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 3, 1'b1, 1'b0);
    applyStimulus("run_inc_ignored", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 3, 1'b1, 1'b0);
    holdCycles("run03", 2, 0, 0, 3, 1'b1, 1'b0);
    applyStimulus("tick_002", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b0);
    holdCycles("run02", 3, 0, 0, 2, 1'b1, 1'b0);
    applyStimulus("tick_001", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0);
    holdCycles("run01", 3, 0, 0, 1, 1'b1, 1'b0);
    applyStimulus("tick_done", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    applyStimulus("done_inc_ignored", 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    holdCycles("done_hold", 22, 0, 0, 0, 1'b0, 1'b1);
    applyStimulus("done_ack", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1'b0, 1'b0);

    // Preset 1:00 for pause / resume checks.
    applyStimulus("pre_min", 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 3, 1'b0, 1'b0);
    for (int i = 1; i <= 57; i++) begin
      s = (3 + i) % 60;
      applyStimulus($sformatf("pre100_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1, s / 10, s % 10, 1'b0, 1'b0);
    end
    applyStimulus("start_100", 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 0, 1'b1, 1'b0);
    holdCycles("run100", 3, 1, 0, 0, 1'b1, 1'b0);
    applyStimulus("tick_059", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 9, 1'b1, 1'b0);
    applyStimulus("pause", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 9, 1'b0, 1'b0);
    holdCycles("paused", 20, 0, 5, 9, 1'b0, 1'b0);
    applyStimulus("resume", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 9, 1'b1, 1'b0);
    holdCycles("run059", 3, 0, 5, 9, 1'b1, 1'b0);
    applyStimulus("tick_058", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 8, 1'b1, 1'b0);

    // Pause exactly on the tick cycle: decrement suppressed, resume ticks at once.
    holdCycles("run058", 3, 0, 5, 8, 1'b1, 1'b0);
    applyStimulus("pause_on_tick", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 8, 1'b0, 1'b0);
    holdCycles("paused2", 2, 0, 5, 8, 1'b0, 1'b0);
    applyStimulus("resume2", 1'b1, 1'b0, 1'b0, 1'b0, 0, 5, 8, 1'b1, 1'b0);
    applyStimulus("tick_first_run", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 7, 1'b1, 1'b0);

    // reset_time beats start_stop and the increments.
    applyStimulus("rt_beats_ss", 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0);
    applyStimulus("rt_beats_inc", 1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b0);
    applyStimulus("both_inc", 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 1, 1'b0, 1'b0);

    // Preset 0:10 to exercise the tens borrow.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus($sformatf("pre010_m%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, (2 + i) % 8, 0, 1, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 9; i++) begin
      s = 1 + i;
      applyStimulus($sformatf("pre010_s%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 0, s / 10, s % 10, 1'b0, 1'b0);
    end
    applyStimulus("start_010", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b0);
    holdCycles("run010", 3, 0, 1, 0, 1'b1, 1'b0);
    applyStimulus("tick_009", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9, 1'b1, 1'b0);
    holdCycles("run009", 1, 0, 0, 9, 1'b1, 1'b0);
    applyStimulus("pause3", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 9, 1'b0, 1'b0);
    applyStimulus("rt_in_pause", 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1'b0, 1'b0);

    // rst mid-run discards the edited preset and restarts the display boot.
    applyStimulus("start_again", 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 1'b1, 1'b0);
    holdCycles("run_again", 2, 0, 1, 0, 1'b1, 1'b0);
    doReset();
    holdCycles("post_reset", 9, 1, 0, 0, 1'b0, 1'b0);

    // Let the monitor drain the last expectation, bounded.
    for (int i = 0; i < 4 && expQueue.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQueue.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d required 0", expQueue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
